// File: rtl/rst_seq_sync.sv
// rst_seq_sync: reset synchronizer and sequencer.
// An asynchronous active-low reset and a synchronous software request drive a
// three-state sequencer. After a minimum assertion time it releases NUM_CH
// active-low resets one at a time, starting with bit 0, with GAP edges between
// releases. Each channel can be held in reset through hold[k].
module rst_seq_sync #(
  parameter int NUM_STAGES = 2,
  parameter int NUM_CH     = 3,
  parameter int GAP        = 4,
  parameter int MIN_ASSERT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] hold,
  output logic [NUM_CH-1:0] sync_rst,
  output logic              rst_done
);

  localparam int CNT_MAX = (MIN_ASSERT > GAP) ? MIN_ASSERT : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0] MA_LAST  = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t               state;
  logic [NUM_STAGES-1:0] sync_q;
  logic                 rst_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [NUM_CH-1:0]    next_therm;
  logic [NUM_CH-1:0]    due_mask;
  logic                 hold_due;

  // Synchronizer chain: ones shift in after rst rises; it clears at once when rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign rst_s = sync_q[NUM_STAGES-1];

  // The released channels form a thermometer code. The next channel due is the
  // lowest zero bit. Its hold input decides whether the sequence stalls.
  assign next_therm = (sync_rst << 1) | NUM_CH'(1);
  assign due_mask   = next_therm & ~sync_rst;
  assign hold_due   = |(hold & due_mask);

  // Sequencer FSM. All outputs are registered here. A software request clears
  // every output on the edge where it is sampled, and it overrides any release due on that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_ASSERT;
      cnt      <= '0;
      idx      <= '0;
      sync_rst <= '0;
      rst_done <= 1'b0;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (sw_rst_req) begin
            cnt <= '0;
          end else if (rst_s) begin
            if (cnt == MA_LAST) begin
              if (!hold_due) begin
                sync_rst <= NUM_CH'(1);
                cnt      <= '0;
                idx      <= IDX_W'(1);
                if (NUM_CH == 1) begin
                  rst_done <= 1'b1;
                  state    <= ST_DONE;
                end else begin
                  state    <= ST_RELEASE;
                end
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        ST_RELEASE: begin
          if (sw_rst_req) begin
            sync_rst <= '0;
            rst_done <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            state    <= ST_ASSERT;
          end else if (cnt == GAP_LAST) begin
            if (!hold_due) begin
              sync_rst <= next_therm;
              cnt      <= '0;
              idx      <= idx + IDX_W'(1);
              if (idx == LAST_CH) begin
                rst_done <= 1'b1;
                state    <= ST_DONE;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          if (sw_rst_req) begin
            sync_rst <= '0;
            rst_done <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            state    <= ST_ASSERT;
          end
        end

        default: begin
          sync_rst <= '0;
          rst_done <= 1'b0;
          cnt      <= '0;
          idx      <= '0;
          state    <= ST_ASSERT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_sync.sv
// tb_rst_seq_sync: scoreboard bench for rst_seq_sync with a timing-rule reference model.
module tb_rst_seq_sync;

  localparam int NUM_STAGES = 2;
  localparam int NUM_CH     = 3;
  localparam int GAP        = 4;
  localparam int MIN_ASSERT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sw_rst_req = 1'b0;
  logic [NUM_CH-1:0] hold = '0;
  logic [NUM_CH-1:0] sync_rst;
  logic              rst_done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [NUM_CH-1:0] s;
    logic              d;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: edges seen with rst high, channels released so far,
  // and edges since the last anchor (edge S or the most recent release).
  int  rst_hi = 0;
  int  n_rel  = 0;
  int  t_since = 0;
  bit  prior_sync;

  rst_seq_sync #(
    .NUM_STAGES(NUM_STAGES),
    .NUM_CH(NUM_CH),
    .GAP(GAP),
    .MIN_ASSERT(MIN_ASSERT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_rst_req(sw_rst_req),
    .hold(hold),
    .sync_rst(sync_rst),
    .rst_done(rst_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NUM_CH:0] act, input logic [NUM_CH:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got {sync_rst,rst_done}=%b required %b at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: applies the release rules edge by edge and pushes the expected outputs.
  always @(posedge clk) begin
    if (!rst) begin
      rst_hi  = 0;
      n_rel   = 0;
      t_since = 0;
    end else begin
      prior_sync = (rst_hi >= NUM_STAGES);
      if (rst_hi < 100) rst_hi++;
      if (sw_rst_req || !prior_sync) begin
        n_rel   = 0;
        t_since = 0;
      end else if (n_rel < NUM_CH) begin
        t_since++;
        if (t_since >= ((n_rel == 0) ? MIN_ASSERT : GAP) && !hold[n_rel]) begin
          n_rel++;
          t_since = 0;
        end
      end
    end
    exp_q.push_back({NUM_CH'((1 << n_rel) - 1), (n_rel == NUM_CH)});
  end

  // Monitor: compares the registered outputs just after every edge with the oldest expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("scoreboard", {sync_rst, rst_done}, {e.s, e.d});
    end
  end

  // Waits for one edge and settles past the monitor's sample point.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [NUM_CH-1:0] hold_val);
    @(negedge clk);
    rst = 1'b0;
    sw_rst_req = 1'b0;
    hold = hold_val;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2;
    chk("reset_state", {sync_rst, rst_done}, '0);

    // Basic sequence: rst released just before E1.
    do_reset('0);
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 9)  chk("basic_e9",  {sync_rst, rst_done}, 4'b0000);
      if (e == 10) chk("basic_e10", {sync_rst, rst_done}, 4'b0010);
      if (e == 13) chk("basic_e13", {sync_rst, rst_done}, 4'b0010);
      if (e == 14) chk("basic_e14", {sync_rst, rst_done}, 4'b0110);
      if (e == 17) chk("basic_e17", {sync_rst, rst_done}, 4'b0110);
      if (e == 18) chk("basic_e18", {sync_rst, rst_done}, 4'b1111);
    end

    // Software request in DONE, sampled at edge Ex.
    @(negedge clk);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    #3;
    chk("sw_done_ex", {sync_rst, rst_done}, 4'b0000);
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e == 7) chk("sw_done_ex7", {sync_rst, rst_done}, 4'b0000);
      if (e == 8) chk("sw_done_ex8", {sync_rst, rst_done}, 4'b0010);
    end

    // Asynchronous reset in the middle of the sequence.
    #3;
    rst = 1'b0;
    #1;
    chk("async_assert", {sync_rst, rst_done}, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) step();
    chk("async_rerun_done", {sync_rst, rst_done}, 4'b1111);

    // hold[1] stalls channel 1 until it is sampled low at E20.
    do_reset(3'b010);
    for (int e = 1; e <= 24; e++) begin
      step();
      if (e == 19) begin
        chk("hold_e19", {sync_rst, rst_done}, 4'b0010);
        @(negedge clk);
        hold = '0;
      end
      if (e == 20) chk("hold_e20", {sync_rst, rst_done}, 4'b0110);
      if (e == 23) chk("hold_e23", {sync_rst, rst_done}, 4'b0110);
      if (e == 24) chk("hold_e24", {sync_rst, rst_done}, 4'b1111);
    end

    // Software request at E6 while still asserting restarts the count.
    do_reset('0);
    for (int e = 1; e <= 15; e++) begin
      step();
      if (e == 5) begin
        @(negedge clk);
        sw_rst_req = 1'b1;
      end
      if (e == 6) begin
        @(negedge clk);
        sw_rst_req = 1'b0;
      end
      if (e == 10) chk("sw_assert_e10", {sync_rst, rst_done}, 4'b0000);
      if (e == 13) chk("sw_assert_e13", {sync_rst, rst_done}, 4'b0000);
      if (e == 14) chk("sw_assert_e14", {sync_rst, rst_done}, 4'b0010);
    end

    // Software request coincident with channel 1 being due at E14.
    do_reset('0);
    for (int e = 1; e <= 22; e++) begin
      step();
      if (e == 13) begin
        @(negedge clk);
        sw_rst_req = 1'b1;
      end
      if (e == 14) begin
        chk("sw_coinc_e14", {sync_rst, rst_done}, 4'b0000);
        @(negedge clk);
        sw_rst_req = 1'b0;
      end
      if (e == 21) chk("sw_coinc_e21", {sync_rst, rst_done}, 4'b0000);
      if (e == 22) chk("sw_coinc_e22", {sync_rst, rst_done}, 4'b0010);
    end

    // Randomized traffic checked only by the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NUM_CH; k++) hold[k] = ($urandom_range(0, 3) == 0);
      sw_rst_req = ($urandom_range(0, 59) == 0);
      if (!rst) rst = ($urandom_range(0, 1) == 0);
      else if ($urandom_range(0, 199) == 0) rst = 1'b0;
    end

    @(negedge clk);
    hold = '0;
    sw_rst_req = 1'b0;
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
